// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
// Takes one complete result matrix C in a single valid cycle and streams it
// out one element per beat over a valid/ready handshake. Each beat carries
// the element's row and column and marks the final element with last_o.
//
// Build option: define MATRIX_RESULT_STREAMER_COL_MAJOR_EN for column-major
// beat order. Without it (the default) beats are row-major.

module matrix_result_streamer #(
    parameter int A_ROWS       = 8,
    parameter int B_COLUMNS    = 5,
    parameter int C_DATA_WIDTH = 18,
    parameter int ROW_W        = (A_ROWS > 1) ? $clog2(A_ROWS) : 1,
    parameter int COL_W        = (B_COLUMNS > 1) ? $clog2(B_COLUMNS) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    valid_i,
    input  logic [C_DATA_WIDTH-1:0] c_i [A_ROWS*B_COLUMNS],
    output logic                    ready_o,
    output logic [C_DATA_WIDTH-1:0] data_o,
    output logic [ROW_W-1:0]        row_o,
    output logic [COL_W-1:0]        col_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    last_o,
    output logic                    overrun_o
);

    localparam int N     = A_ROWS * B_COLUMNS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(A_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(B_COLUMNS - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]              state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [ROW_W-1:0]        row_q;
    logic [COL_W-1:0]        col_q;
    logic [C_DATA_WIDTH-1:0] buffer_q [N];
    logic                    overrun_q;

    logic                    streaming;
    logic                    idx_at_end;
    logic                    capture;
    logic                    finish;
    logic                    advance;
    logic [IDX_W-1:0]        rd_addr;

    assign streaming  = (state_q == ST_STREAM);
    assign idx_at_end = (idx_q == IDX_LAST);

    // A new matrix can be taken when idle, or on the very cycle the final
    // beat of the current matrix is handed off, so matrices stream with no
    // bubble in between. This is why ready_o looks at ready_i.
    assign valid_o = streaming;
    assign last_o  = streaming & idx_at_end;
    assign ready_o = !streaming | (ready_i & last_o);

    assign capture = valid_i & ready_o;
    assign finish  = streaming & ready_i & idx_at_end & !valid_i;
    assign advance = streaming & ready_i & !idx_at_end;

    // Beat sequencing: idx counts beats for last_o, while row/col counters
    // walk the matrix in the configured order so no divider is needed.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else if (capture) begin
            state_q <= ST_STREAM;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else if (finish) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else if (advance) begin
            idx_q <= idx_q + 1'b1;
`ifdef MATRIX_RESULT_STREAMER_COL_MAJOR_EN
            if (row_q == ROW_LAST) begin
                row_q <= '0;
                col_q <= col_q + 1'b1;
            end else begin
                row_q <= row_q + 1'b1;
            end
`else
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
`endif
        end
    end

    // Capture buffer is pure datapath; outputs are gated by valid_o, so it
    // needs no reset. A dropped (overrun) matrix never reaches it.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            buffer_q <= c_i;
        end
    end

    // Flag a matrix that arrived while the streamer could not take it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= valid_i & !ready_o;
        end
    end

`ifdef MATRIX_RESULT_STREAMER_COL_MAJOR_EN
    assign rd_addr = IDX_W'(int'(row_q) * B_COLUMNS + int'(col_q));
`else
    assign rd_addr = idx_q;
`endif

    assign data_o    = streaming ? buffer_q[rd_addr] : '0;
    assign row_o     = streaming ? row_q : '0;
    assign col_o     = streaming ? col_q : '0;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer
// Self-checking bench for matrix_result_streamer. A queue-based model holds
// the beats still owed for the current matrix; every cycle the DUT outputs
// are compared against that model. Honours MATRIX_RESULT_STREAMER_COL_MAJOR_EN.

module tb_matrix_result_streamer;

    localparam int A_ROWS    = 8;
    localparam int B_COLUMNS = 5;
    localparam int W         = 18;
    localparam int ROW_W     = 3;
    localparam int COL_W     = 3;
    localparam int N         = A_ROWS * B_COLUMNS;
    localparam int OUT_W     = 4 + W + ROW_W + COL_W;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             valid_i;
    logic [W-1:0]     c_i [N];
    logic             ready_o;
    logic [W-1:0]     data_o;
    logic [ROW_W-1:0] row_o;
    logic [COL_W-1:0] col_o;
    logic             valid_o;
    logic             ready_i;
    logic             last_o;
    logic             overrun_o;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [W-1:0]     data;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             last;
    } beat_t;

    beat_t exp_q[$];
    logic  exp_overrun;

    logic [OUT_W-1:0] exp_vec;
    logic [OUT_W-1:0] obs_vec;

    matrix_result_streamer #(
        .A_ROWS(A_ROWS),
        .B_COLUMNS(B_COLUMNS),
        .C_DATA_WIDTH(W),
        .ROW_W(ROW_W),
        .COL_W(COL_W)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .valid_i(valid_i),
        .c_i(c_i),
        .ready_o(ready_o),
        .data_o(data_o),
        .row_o(row_o),
        .col_o(col_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .last_o(last_o),
        .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected outputs right now, given the beats still owed and ready_i.
    function automatic logic [OUT_W-1:0] expected_outputs();
        logic  ev;
        logic  er;
        beat_t b;
        ev = (exp_q.size() > 0);
        b  = ev ? exp_q[0] : '0;
        er = !ev || (ready_i && exp_q.size() == 1);
        return {ev, er, ev && b.last, exp_overrun, b.data, b.row, b.col};
    endfunction

    function automatic logic [OUT_W-1:0] observed_outputs();
        return {valid_o, ready_o, last_o, overrun_o, data_o, row_o, col_o};
    endfunction

    // Build the list of beats for the matrix currently on c_i.
    task automatic push_matrix();
        beat_t b;
        int r;
        int c;
        for (int k = 0; k < N; k++) begin
`ifdef MATRIX_RESULT_STREAMER_COL_MAJOR_EN
            r = k % A_ROWS;
            c = k / A_ROWS;
`else
            r = k / B_COLUMNS;
            c = k % B_COLUMNS;
`endif
            b.data = c_i[r * B_COLUMNS + c];
            b.row  = ROW_W'(r);
            b.col  = COL_W'(c);
            b.last = (k == N - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive(input logic v, input logic r);
        @(negedge clk_i);
        valid_i = v;
        ready_i = r;
        #1;
    endtask

    // Advance the model across the rising edge using the driven inputs.
    task automatic model_step();
        logic ev;
        logic er;
        @(posedge clk_i);
        ev = (exp_q.size() > 0);
        er = !ev || (ready_i && exp_q.size() == 1);
        if (ev && ready_i) void'(exp_q.pop_front());
        if (valid_i && er) push_matrix();
        exp_overrun = valid_i && !er;
    endtask

    task automatic fill_seq(input int base);
        for (int k = 0; k < N; k++) c_i[k] = W'(base + k);
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) c_i[k] = W'($urandom);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        fill_seq(0);
        exp_q.delete();
        exp_overrun = 1'b0;
        #1;
        exp_vec = expected_outputs();
        obs_vec = observed_outputs();
        tests_run++;
        if (obs_vec !== exp_vec) begin
            tests_failed++;
            $display("[TB] FAIL reset_during: got %h expected %h", obs_vec, exp_vec);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        obs_vec = observed_outputs();
        tests_run++;
        if (obs_vec !== exp_vec) begin
            tests_failed++;
            $display("[TB] FAIL reset_after: got %h expected %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_basic_stream();
        int last_seen = 0;
        fill_seq(1);
        for (int cyc = 0; cyc < N + 4; cyc++) begin
            drive(cyc == 0, 1'b1);
            exp_vec = expected_outputs();
            obs_vec = observed_outputs();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL basic cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec);
            end
            if (valid_o === 1'b1 && last_o === 1'b1) last_seen++;
            model_step();
        end
        tests_run++;
        if (last_seen != 1) begin
            tests_failed++;
            $display("[TB] FAIL basic_last_count: got %0d expected 1", last_seen);
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        int held = 0;
        logic r;
        fill_seq(1);
        for (int cyc = 0; cyc < N + 8; cyc++) begin
            r = !(accepted == 2 && held < 3);
            if (!r) held++;
            drive(cyc == 0, r);
            exp_vec = expected_outputs();
            obs_vec = observed_outputs();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL backpressure cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec);
            end
            if (exp_q.size() > 0 && r) accepted++;
            model_step();
        end
    endtask

    task automatic test_back_to_back();
        logic sent = 1'b0;
        logic v;
        int valid_cycles = 0;
        int overruns = 0;
        fill_seq(1);
        for (int cyc = 0; cyc < 2 * N + 5; cyc++) begin
            v = (cyc == 0) || (!sent && exp_q.size() == 1);
            if (v && cyc != 0) begin
                fill_seq(100);
                sent = 1'b1;
            end
            drive(v, 1'b1);
            exp_vec = expected_outputs();
            obs_vec = observed_outputs();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec);
            end
            if (valid_o === 1'b1) valid_cycles++;
            if (overrun_o === 1'b1) overruns++;
            model_step();
        end
        tests_run++;
        if (valid_cycles != 2 * N || overruns != 0) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_continuity: got %0d valid/%0d overrun expected %0d/0",
                     valid_cycles, overruns, 2 * N);
        end
    endtask

    task automatic test_overrun();
        int accepted = 0;
        int pulses = 0;
        logic sent = 1'b0;
        logic v;
        fill_seq(1);
        for (int cyc = 0; cyc < N + 5; cyc++) begin
            v = (cyc == 0) || (!sent && accepted == 9);
            if (v && cyc != 0) begin
                for (int k = 0; k < N; k++) c_i[k] = '1;
                sent = 1'b1;
            end
            drive(v, 1'b1);
            exp_vec = expected_outputs();
            obs_vec = observed_outputs();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL overrun cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec);
            end
            if (overrun_o === 1'b1) pulses++;
            if (exp_q.size() > 0) accepted++;
            model_step();
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("[TB] FAIL overrun_pulse_count: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_reset_mid_stream();
        fill_seq(1);
        for (int cyc = 0; cyc < 20; cyc++) begin
            drive(cyc == 0, 1'b1);
            exp_vec = expected_outputs();
            obs_vec = observed_outputs();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL midreset_pre cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec);
            end
            model_step();
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        reset_i = 1'b1;
        #1;
        exp_q.delete();
        exp_overrun = 1'b0;
        exp_vec = expected_outputs();
        obs_vec = observed_outputs();
        tests_run++;
        if (obs_vec !== exp_vec) begin
            tests_failed++;
            $display("[TB] FAIL midreset_async: got %h expected %h", obs_vec, exp_vec);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        fill_seq(500);
        for (int cyc = 0; cyc < N + 3; cyc++) begin
            drive(cyc == 0, 1'b1);
            exp_vec = expected_outputs();
            obs_vec = observed_outputs();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL midreset_fresh cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec);
            end
            model_step();
        end
    endtask

    task automatic test_random_traffic();
        logic v;
        logic r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 3) != 0);
            if (v) fill_random();
            drive(v, r);
            exp_vec = expected_outputs();
            obs_vec = observed_outputs();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL random cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec);
            end
            model_step();
        end
        for (int cyc = 0; cyc < N + 3; cyc++) begin
            drive(1'b0, 1'b1);
            exp_vec = expected_outputs();
            obs_vec = observed_outputs();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL random_drain cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec);
            end
            model_step();
        end
        tests_run++;
        if (valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL random_idle: got valid_o=%b expected 0", valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid_stream();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/matrix_result_streamer.md
# matrix_result_streamer

Consumer-side companion to the matrix multiplier. It captures a full result matrix C, presented as a parallel array with a one-cycle valid, and streams it out one element per beat over a valid/ready handshake. Each beat carries row/column indices and a last marker. The block sits between the multiplier's registered result outputs and any narrow downstream sink, such as a FIFO, bus writer or checker.

## Interface
Parameters:
- `A_ROWS`, default 8: rows of C.
- `B_COLUMNS`, default 5: columns of C.
- `C_DATA_WIDTH`, default 18: width of one C element (2·8 + clog2(4)).
- `ROW_W`, default `$clog2(A_ROWS)` (min 1): width of the row index.
- `COL_W`, default `$clog2(B_COLUMNS)` (min 1): width of the column index.

Ports:
- `clk_i` in 1: clock. All state updates on the rising edge.
- `reset_i` in 1: reset. One clock; reset is asynchronous and active-high.
- `valid_i` in 1: single-cycle strobe; `c_i` holds a complete matrix.
- `c_i` in `[C_DATA_WIDTH-1:0]` × `A_ROWS*B_COLUMNS`: result array, row-major, index `r*B_COLUMNS+c`.
- `ready_o` out 1: combinational; a `valid_i` sampled this edge is accepted.
- `data_o` out `C_DATA_WIDTH`: current element.
- `row_o` out `ROW_W`: row index of `data_o`.
- `col_o` out `COL_W`: column index of `data_o`.
- `valid_o` out 1: beat valid.
- `ready_i` in 1: downstream accepts the beat.
- `last_o` out 1: current beat is the final element of the matrix.
- `overrun_o` out 1: one-cycle pulse; a matrix was dropped.

## Operation
- Capture buffer holds `A_ROWS*B_COLUMNS` elements. A beat counter `idx` runs from 0 to N-1, where N = `A_ROWS*B_COLUMNS`.
- FSM has two states:
  - IDLE: `valid_o`=0.
  - STREAM: `valid_o`=1.
- `ready_o` = (state==IDLE) | (valid_o & ready_i & last_o).
- Transitions:
  - IDLE & `valid_i`: capture `c_i`, `idx`←0, go to STREAM.
  - STREAM & `ready_i` & !`last_o`: `idx`←`idx`+1.
  - STREAM & `ready_i` & `last_o` & `valid_i`: capture the new matrix, `idx`←0, stay in STREAM (back-to-back, no bubble).
  - STREAM & `ready_i` & `last_o` & !`valid_i`: go to IDLE.
- Output mapping: `data_o`, `row_o` and `col_o` are driven from the buffer at position `idx` per the ordering in Configuration. All three are 0 when `valid_o`=0.
- `last_o` = `valid_o` & (`idx`==N-1).
- Overrun: `valid_i` & !`ready_o` drops the incoming matrix. The buffer and the stream in progress are untouched. `overrun_o`=1 on the following cycle for exactly one cycle.
- No arithmetic on data. Elements pass bit-exact at `C_DATA_WIDTH`. Indices wrap nowhere because the counter is bounded to N-1.

## Timing
- Reset values: `valid_o`=0, `last_o`=0, `overrun_o`=0, `data_o`/`row_o`/`col_o`=0, state IDLE, `idx`=0. `ready_o`=1 during and after reset.
- Reset asserted mid-stream clears the state immediately and asynchronously. The partial matrix is discarded with no `last_o`.
- Latency: `valid_i` sampled at edge E gives `valid_o`=1 with element 0 after E. With `ready_i` held high, the final beat is accepted at edge E+N.
- Throughput: one element per cycle. Back-to-back matrices stream with zero idle cycles.
- Stall: while `valid_o` & !`ready_i`, `data_o`, `row_o`, `col_o` and `last_o` hold stable.
- `valid_o` never deasserts without a handshake, except on reset.
- `ready_o` depends combinationally on `ready_i`. The downstream must not derive `ready_i` from `ready_o`.

## Configuration
- `MATRIX_RESULT_STREAMER_COL_MAJOR_EN`:
  - Defined: beats run in column-major order. For beat k, `col_o` = k / `A_ROWS`, `row_o` = k % `A_ROWS`, and `data_o` = buffer[`row_o`*`B_COLUMNS`+`col_o`]. Implemented with separate row/col counters; no divider.
  - Undefined (default): row-major order. For beat k, `row_o` = k / `B_COLUMNS`, `col_o` = k % `B_COLUMNS`, and `data_o` = buffer[k].
- Handshake, latency and `last_o` are identical in both builds.

## Test plan
- Basic stream: `c_i[k]`=k+1, one `valid_i`, `ready_i`=1. Expect 40 beats with `data_o` 1..40 and `(row_o,col_o)` (0,0),(0,1)…(7,4). `last_o` only on `data_o`=40. `valid_o` falls after edge E+40.
- Backpressure: `ready_i` low during beats 3–5. Expect `data_o`=3 and `(0,2)` held for 3 cycles, then 4..40 continue with no skips or duplicates.
- Back-to-back: assert a second `valid_i` with `c_i[k]`=100+k in the cycle where the beat `data_o`=40 is accepted. Expect the next cycle to carry `data_o`=100 with `valid_o` continuous, and `overrun_o` stays 0.
- Overrun: a second `valid_i` (`c_i[k]`=0x3FFFF) arrives at beat 10. Expect `overrun_o` pulsed for 1 cycle and the stream 1..40 unaffected.
- Reset mid-stream: assert `reset_i` at beat 20. Expect `valid_o`/`last_o`/`data_o`=0 immediately and `ready_o`=1. A fresh matrix afterwards streams from `(0,0)`.
- With `MATRIX_RESULT_STREAMER_COL_MAJOR_EN`: basic stream stimulus. Expect `data_o` 1,6,11,…,36,2,7,…,40. `last_o` is on 40 at `(7,4)`.
